// File: rtl/weight_buf_pkg.sv
// Shared types and sizing helpers for the ping-pong kernel weight buffer.
package weight_buf_pkg;

  typedef enum logic [1:0] {StIdle, StFetch, StFull} fetch_state_e;

  localparam logic TAP_MODE_FULL   = 1'b0;
  localparam logic TAP_MODE_SINGLE = 1'b1;

  function automatic int buffer_num(int x_pe, int x_mesh, int data_len);
    return 8 * x_pe * x_mesh / data_len;
  endfunction

  function automatic int ker_width(int x_pe, int x_mesh, int ktaps);
    return x_pe * x_mesh * 8 * ktaps;
  endfunction

endpackage

// File: rtl/weight_bank_pool.sv
// Two banks of BUFFER_NUM simple dual-port BRAMs: write-bank decode and read-bank output mux.
module weight_bank_pool #(
  parameter int ADDR_LEN     = 10,
  parameter int DATA_LEN     = 64,
  parameter int DDR_DATA_LEN = 256,
  parameter int BUFFER_NUM   = 32,
  parameter int RD_LAT       = 1
) (
  input  logic                           clk,
  input  logic [DDR_DATA_LEN-1:0]        data_wr,
  input  logic [ADDR_LEN-1:0]            wr_addr,
  input  logic [BUFFER_NUM-1:0]          wr_en,
  input  logic                           wr_bank,
  input  logic [ADDR_LEN-1:0]            rd_addr,
  input  logic                           rd_bank,
  output logic [BUFFER_NUM*DATA_LEN-1:0] rd_data
);
  localparam int DEPTH = 2 ** ADDR_LEN;
  localparam int GROUP = DDR_DATA_LEN / DATA_LEN;

  logic [1:0][BUFFER_NUM*DATA_LEN-1:0] w_bank_q;
  logic [BUFFER_NUM*DATA_LEN-1:0]      w_mux;
  logic                                r_sel;

  for (genvar bk = 0; bk < 2; bk++) begin : g_bank
    for (genvar b = 0; b < BUFFER_NUM; b++) begin : g_bram
      logic [DATA_LEN-1:0] r_mem [DEPTH];
      logic [DATA_LEN-1:0] r_q;
      // Loader word is replicated: BRAM b takes lane b mod GROUP.
      always_ff @(posedge clk) begin
        if (wr_en[b] && (wr_bank == 1'(bk))) begin
          r_mem[wr_addr] <= data_wr[(b % GROUP)*DATA_LEN +: DATA_LEN];
        end
        r_q <= r_mem[rd_addr];
      end
      assign w_bank_q[bk][b*DATA_LEN +: DATA_LEN] = r_q;
    end
  end

  always_ff @(posedge clk) begin
    r_sel <= rd_bank;
  end

  assign w_mux = r_sel ? w_bank_q[1] : w_bank_q[0];

  if (RD_LAT == 2) begin : g_lat2
    logic [BUFFER_NUM*DATA_LEN-1:0] r_out;
    always_ff @(posedge clk) begin
      r_out <= w_mux;
    end
    assign rd_data = r_out;
  end else begin : g_lat1
    assign rd_data = w_mux;
  end

endmodule

// File: rtl/weight_buffer_pp.sv
// Ping-pong kernel weight buffer: fetch FSM, address counter, tap shadow register and
// valid/ready output slot. Read-word byte m = i*X_MESH + j belongs to PE i, row j.
module weight_buffer_pp
  import weight_buf_pkg::*;
#(
  parameter int X_PE         = 16,
  parameter int X_MESH       = 16,
  parameter int ADDR_LEN     = 10,
  parameter int DATA_LEN     = 64,
  parameter int DDR_DATA_LEN = 256,
  parameter int KTAPS        = 9,
  parameter int RD_LAT       = 1,
  parameter int BUFFER_NUM   = buffer_num(X_PE, X_MESH, DATA_LEN)
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [DDR_DATA_LEN-1:0]                     data_wr,
  input  logic [ADDR_LEN-1:0]                         wr_addr,
  input  logic [BUFFER_NUM-1:0]                       wr_en,
  input  logic                                        wr_bank,
  input  logic                                        rd_conf,
  input  logic [ADDR_LEN-1:0]                         st_rd_addr,
  input  logic                                        rd_bank,
  input  logic                                        tap_mode,
  output logic                                        idle,
  output logic                                        conf_err,
  output logic [1:0]                                  rd_bank_busy,
  output logic [ker_width(X_PE, X_MESH, KTAPS)-1:0]   ker_out,
  output logic                                        ker_valid,
  input  logic                                        ker_ready
);
  localparam int WORD_W = BUFFER_NUM * DATA_LEN;
  localparam int KER_W  = ker_width(X_PE, X_MESH, KTAPS);
  localparam int NBYTE  = X_PE * X_MESH;
  localparam int CNT_W  = $clog2(KTAPS + RD_LAT + 2);
  localparam logic [CNT_W-1:0] LAT = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] KT  = CNT_W'(KTAPS);

  fetch_state_e        r_state, w_state_nxt;
  logic [ADDR_LEN-1:0] r_addr;
  logic [CNT_W-1:0]    r_cnt, w_ntaps, w_tap;
  logic                r_bank, r_mode, r_ker_valid;
  logic [WORD_W-1:0]   r_shadow [KTAPS];
  logic [WORD_W-1:0]   w_rd_data;
  logic [KER_W-1:0]    r_ker, w_ker;
  logic                w_accept, w_issue, w_capture, w_done, w_slot_free, w_xfer;

  weight_bank_pool #(
    .ADDR_LEN    (ADDR_LEN),
    .DATA_LEN    (DATA_LEN),
    .DDR_DATA_LEN(DDR_DATA_LEN),
    .BUFFER_NUM  (BUFFER_NUM),
    .RD_LAT      (RD_LAT)
  ) u_pool (
    .clk    (clk),
    .data_wr(data_wr),
    .wr_addr(wr_addr),
    .wr_en  (wr_en),
    .wr_bank(wr_bank),
    .rd_addr(r_addr),
    .rd_bank(r_bank),
    .rd_data(w_rd_data)
  );

  // r_cnt counts cycles since accept: taps issue while r_cnt < N, land RD_LAT later.
  assign w_ntaps     = (r_mode == TAP_MODE_SINGLE) ? CNT_W'(1) : KT;
  assign w_tap       = r_cnt - LAT;
  assign w_accept    = (r_state == StIdle) && rd_conf;
  assign w_issue     = (r_state == StFetch) && (r_cnt < w_ntaps);
  assign w_capture   = (r_state == StFetch) && (r_cnt >= LAT) && (r_cnt < w_ntaps + LAT);
  assign w_done      = (r_state == StFetch) && (r_cnt == w_ntaps + LAT);
  assign w_slot_free = !r_ker_valid || ker_ready;
  assign w_xfer      = (w_done || (r_state == StFull)) && w_slot_free;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (rd_conf) w_state_nxt = StFetch;
      StFetch: if (w_done) w_state_nxt = w_slot_free ? StIdle : StFull;
      StFull:  if (w_slot_free) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_bank  <= 1'b0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr <= st_rd_addr;
        r_cnt  <= '0;
        r_bank <= rd_bank;
        r_mode <= tap_mode;
      end else begin
        if (w_issue) r_addr <= r_addr + ADDR_LEN'(1);
        if (r_state == StFetch) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Cleared on accept so single-tap kernels carry zeros in taps 1..KTAPS-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < KTAPS; k++) r_shadow[k] <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < KTAPS; k++) r_shadow[k] <= '0;
    end else if (w_capture) begin
      for (int k = 0; k < KTAPS; k++) begin
        if (w_tap == CNT_W'(k)) r_shadow[k] <= w_rd_data;
      end
    end
  end

  always_comb begin
    w_ker = '0;
    for (int m = 0; m < NBYTE; m++) begin
      for (int k = 0; k < KTAPS; k++) begin
        w_ker[(m*KTAPS + k)*8 +: 8] = r_shadow[k][m*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ker       <= '0;
      r_ker_valid <= 1'b0;
    end else if (w_xfer) begin
      r_ker       <= w_ker;
      r_ker_valid <= 1'b1;
    end else if (r_ker_valid && ker_ready) begin
      r_ker_valid <= 1'b0;
    end
  end

  assign idle         = (r_state == StIdle);
  assign conf_err     = rd_conf && (r_state != StIdle);
  assign rd_bank_busy = (r_state == StFetch) ? (r_bank ? 2'b10 : 2'b01) : 2'b00;
  assign ker_out      = r_ker;
  assign ker_valid    = r_ker_valid;

endmodule
